multi_channel_convergence_counter: RTL and testbench

MULTI_CHANNEL_CONVERGENCE_COUNTER -- requirements
Module: multi_channel_convergence_counter

---
 rtl/multi_channel_convergence_counter.sv | 136 +++++++++++++
 tb/tb_multi_channel_convergence_counter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_convergence_counter.sv
// Bank of independent terminal-count counters, each with its own limit, mode
// (wrap / saturate / one-shot) and IDLE-RUN-DONE control FSM.
module multi_channel_convergence_counter #(
  parameter  int WIDTH  = 32,
  parameter  int NUM_CH = 4,
  localparam int CHW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    cfg_we,
  input  logic [CHW-1:0]          cfg_ch,
  input  logic [WIDTH-1:0]        cfg_limit,
  input  logic [1:0]              cfg_mode,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       inc,
  input  logic [NUM_CH-1:0]       clr,
  output logic [NUM_CH*WIDTH-1:0] count_o,
  output logic [NUM_CH-1:0]       event_o,
  output logic [NUM_CH-1:0]       done_o,
  output logic [NUM_CH-1:0]       busy_o,
  output logic                    any_event_o,
  output logic [2*NUM_CH-1:0]     state_dbg_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [1:0] M_SAT = 2'b01;
  localparam logic [1:0] M_ONE = 2'b10;

  // Handshake: none. cfg_we is a single-cycle strobe sampled on the rising
  // edge; it is accepted only when the addressed channel is not in RUN.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam logic [CHW-1:0] CH_IDX = CHW'(c);

    state_e           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] limit_q;
    logic [1:0]       mode_q;
    logic             event_q;
    logic             done_q;
    logic             busy_q;
    logic             hit;
    logic             cfg_acc;

    assign hit     = (state_q == S_RUN) && inc[c] && (count_q == limit_q);
    assign cfg_acc = cfg_we && (cfg_ch == CH_IDX) && (state_q != S_RUN);

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        state_q <= S_IDLE;
        count_q <= '0;
        limit_q <= '1;
        mode_q  <= 2'b00;
        event_q <= 1'b0;
        done_q  <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        event_q <= 1'b0;
        if (clr[c]) begin
          state_q <= S_IDLE;
          count_q <= '0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end else begin
          case (state_q)
            S_IDLE, S_DONE: begin
              if (start[c]) begin
                state_q <= S_RUN;
                busy_q  <= 1'b1;
                count_q <= '0;
                done_q  <= 1'b0;
              end else if (cfg_acc && (count_q > cfg_limit)) begin
                // A finished channel may be given a lower limit; keep count <= limit.
                count_q <= cfg_limit;
              end
            end
            S_RUN: begin
              if (inc[c]) begin
                if (!hit) begin
                  count_q <= count_q + 1'b1;
                end else begin
                  case (mode_q)
                    M_SAT: begin
                      done_q  <= 1'b1;
                      event_q <= !done_q;
                    end
                    M_ONE: begin
                      state_q <= S_DONE;
                      busy_q  <= 1'b0;
                      done_q  <= 1'b1;
                      event_q <= 1'b1;
                    end
                    default: begin
                      count_q <= '0;
                      event_q <= 1'b1;
                    end
                  endcase
                end
              end
            end
            default: begin
              state_q <= S_IDLE;
              count_q <= '0;
              done_q  <= 1'b0;
              busy_q  <= 1'b0;
            end
          endcase
        end
        if (cfg_acc) begin
          limit_q <= cfg_limit;
          mode_q  <= cfg_mode;
        end
      end
    end

    assign count_o[c*WIDTH +: WIDTH] = count_q;
    assign event_o[c]                = event_q;
    assign done_o[c]                 = done_q;
    assign busy_o[c]                 = busy_q;
    assign state_dbg_o[2*c +: 2]     = state_q;

    a_count_le_limit : assert property (@(posedge clk) disable iff (!resetn)
      count_q <= limit_q);
    a_event_from_hit : assert property (@(posedge clk) disable iff (!resetn)
      event_q |-> $past(hit && !clr[c]));
    a_oneshot_excl : assert property (@(posedge clk) disable iff (!resetn)
      (mode_q == M_ONE) |-> !(busy_q && done_q));
  end

  assign any_event_o = |event_o;

endmodule

// File: tb/tb_multi_channel_convergence_counter.sv
// Bench for multi_channel_convergence_counter: directed table, corner sequences
// and random traffic checked against a rule-level reference model.
module tb_multi_channel_convergence_counter;
  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           resetn;
  logic           cfg_we;
  logic [1:0]     cfg_ch;
  logic [W-1:0]   cfg_limit;
  logic [1:0]     cfg_mode;
  logic [N-1:0]   start, inc, clr;
  logic [N*W-1:0] count_o;
  logic [N-1:0]   event_o, done_o, busy_o;
  logic           any_event_o;
  logic [2*N-1:0] state_dbg_o;

  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  multi_channel_convergence_counter #(.WIDTH(W), .NUM_CH(N)) dut (
    .clk(clk), .resetn(resetn), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_limit(cfg_limit), .cfg_mode(cfg_mode), .start(start), .inc(inc),
    .clr(clr), .count_o(count_o), .event_o(event_o), .done_o(done_o),
    .busy_o(busy_o), .any_event_o(any_event_o), .state_dbg_o(state_dbg_o)
  );

  // reference model: running flag, done flag, count, limit, mode per channel
  bit m_run[N];
  bit m_done[N];
  bit m_ev[N];
  int m_count[N];
  int m_limit[N];
  int m_mode[N];

  function automatic void model_reset();
    for (int c = 0; c < N; c++) begin
      m_run[c] = 0; m_done[c] = 0; m_ev[c] = 0;
      m_count[c] = 0; m_limit[c] = (1 << W) - 1; m_mode[c] = 0;
    end
  endfunction

  function automatic void model_step();
    for (int c = 0; c < N; c++) begin
      bit accept;
      accept = cfg_we && (int'(cfg_ch) == c) && !m_run[c];
      m_ev[c] = 0;
      if (clr[c]) begin
        m_run[c] = 0; m_done[c] = 0; m_count[c] = 0;
      end else if (!m_run[c]) begin
        if (start[c]) begin
          m_run[c] = 1; m_done[c] = 0; m_count[c] = 0;
        end else if (accept && m_count[c] > int'(cfg_limit)) begin
          m_count[c] = int'(cfg_limit);
        end
      end else if (inc[c]) begin
        if (m_count[c] != m_limit[c]) begin
          m_count[c] = m_count[c] + 1;
        end else if (m_mode[c] == 1) begin
          m_ev[c] = !m_done[c]; m_done[c] = 1;
        end else if (m_mode[c] == 2) begin
          m_ev[c] = 1; m_done[c] = 1; m_run[c] = 0;
        end else begin
          m_ev[c] = 1; m_count[c] = 0;
        end
      end
      if (accept) begin
        m_limit[c] = int'(cfg_limit);
        m_mode[c]  = int'(cfg_mode);
      end
    end
  endfunction

  // scoreboard
  task automatic compare_model(input string tag);
    logic [N*W-1:0] ec;
    logic [N-1:0]   ee, ed, eb;
    for (int c = 0; c < N; c++) begin
      ec[c*W +: W] = W'(m_count[c]);
      ee[c] = m_ev[c]; ed[c] = m_done[c]; eb[c] = m_run[c];
    end
    checks++;
    if (count_o !== ec || event_o !== ee || done_o !== ed || busy_o !== eb ||
        any_event_o !== (|ee)) begin
      errors++;
      $display("FAIL %s @%0t: got count=%h ev=%b done=%b busy=%b any=%b, want count=%h ev=%b done=%b busy=%b any=%b",
               tag, $time, count_o, event_o, done_o, busy_o, any_event_o, ec, ee, ed, eb, |ee);
    end
  endtask

  // driver tasks
  task automatic drive(input logic [N-1:0] st, input logic [N-1:0] in_v,
                       input logic [N-1:0] cl, input logic we, input logic [1:0] ch,
                       input logic [W-1:0] lim, input logic [1:0] md);
    start = st; inc = in_v; clr = cl;
    cfg_we = we; cfg_ch = ch; cfg_limit = lim; cfg_mode = md;
  endtask

  task automatic idle();
    drive('0, '0, '0, 1'b0, 2'd0, '0, 2'd0);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    compare_model(tag);
  endtask

  task automatic do_reset();
    idle();
    resetn = 1'b0;
    model_reset();
    #1;
    compare_model("reset_async");
    @(negedge clk);
    resetn = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0] st, in_v, cl;
    logic         we;
    logic [1:0]   ch;
    logic [W-1:0] lim;
    logic [1:0]   md;
    logic [31:0]  ecount;
    logic [N-1:0] eev, edone, ebusy;
  } vec_t;

  vec_t tbl[19];
  int   ev_cnt;

  initial begin
    tbl[0]  = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd0, 8'd3, 2'd0, 32'h00000000, 4'b0000, 4'b0000, 4'b0000};
    tbl[1]  = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd1, 8'd5, 2'd1, 32'h00000000, 4'b0000, 4'b0000, 4'b0000};
    tbl[2]  = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd2, 8'd2, 2'd2, 32'h00000000, 4'b0000, 4'b0000, 4'b0000};
    tbl[3]  = '{4'b0111, 4'b0111, 4'b0000, 1'b0, 2'd0, 8'd0, 2'd0, 32'h00000000, 4'b0000, 4'b0000, 4'b0111};
    tbl[4]  = '{4'b0000, 4'b0111, 4'b0000, 1'b0, 2'd0, 8'd0, 2'd0, 32'h00010101, 4'b0000, 4'b0000, 4'b0111};
    tbl[5]  = '{4'b0000, 4'b0111, 4'b0000, 1'b0, 2'd0, 8'd0, 2'd0, 32'h00020202, 4'b0000, 4'b0000, 4'b0111};
    tbl[6]  = '{4'b0000, 4'b0111, 4'b0000, 1'b0, 2'd0, 8'd0, 2'd0, 32'h00020303, 4'b0100, 4'b0100, 4'b0011};
    tbl[7]  = '{4'b0000, 4'b0111, 4'b0000, 1'b0, 2'd0, 8'd0, 2'd0, 32'h00020400, 4'b0001, 4'b0100, 4'b0011};
    tbl[8]  = '{4'b0000, 4'b0111, 4'b0000, 1'b0, 2'd0, 8'd0, 2'd0, 32'h00020501, 4'b0000, 4'b0100, 4'b0011};
    tbl[9]  = '{4'b0000, 4'b0111, 4'b0000, 1'b0, 2'd0, 8'd0, 2'd0, 32'h00020502, 4'b0010, 4'b0110, 4'b0011};
    tbl[10] = '{4'b0000, 4'b0111, 4'b0000, 1'b0, 2'd0, 8'd0, 2'd0, 32'h00020503, 4'b0000, 4'b0110, 4'b0011};
    tbl[11] = '{4'b0000, 4'b0001, 4'b0000, 1'b1, 2'd0, 8'd9, 2'd0, 32'h00020500, 4'b0001, 4'b0110, 4'b0011};
    tbl[12] = '{4'b0101, 4'b0000, 4'b0000, 1'b0, 2'd0, 8'd0, 2'd0, 32'h00000500, 4'b0000, 4'b0010, 4'b0111};
    tbl[13] = '{4'b0010, 4'b0010, 4'b0010, 1'b0, 2'd0, 8'd0, 2'd0, 32'h00000000, 4'b0000, 4'b0000, 4'b0101};
    tbl[14] = '{4'b1000, 4'b0000, 4'b0000, 1'b1, 2'd1, 8'd0, 2'd0, 32'h00000000, 4'b0000, 4'b0000, 4'b1101};
    tbl[15] = '{4'b0010, 4'b1000, 4'b0000, 1'b0, 2'd0, 8'd0, 2'd0, 32'h01000000, 4'b0000, 4'b0000, 4'b1111};
    tbl[16] = '{4'b0000, 4'b0010, 4'b0000, 1'b0, 2'd0, 8'd0, 2'd0, 32'h01000000, 4'b0010, 4'b0000, 4'b1111};
    tbl[17] = '{4'b0000, 4'b0010, 4'b0000, 1'b0, 2'd0, 8'd0, 2'd0, 32'h01000000, 4'b0010, 4'b0000, 4'b1111};
    tbl[18] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 8'd0, 2'd0, 32'h01000000, 4'b0000, 4'b0000, 4'b1111};

    idle();
    resetn = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    compare_model("reset_state");

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].st, tbl[i].in_v, tbl[i].cl, tbl[i].we, tbl[i].ch, tbl[i].lim, tbl[i].md);
      tick("table_model");
      checks++;
      if (count_o !== tbl[i].ecount || event_o !== tbl[i].eev || done_o !== tbl[i].edone ||
          busy_o !== tbl[i].ebusy || any_event_o !== (|tbl[i].eev)) begin
        errors++;
        $display("FAIL table_row%0d: got count=%h ev=%b done=%b busy=%b any=%b, want count=%h ev=%b done=%b busy=%b",
                 i, count_o, event_o, done_o, busy_o, any_event_o,
                 tbl[i].ecount, tbl[i].eev, tbl[i].edone, tbl[i].ebusy);
      end
    end

    // ch3 up to 4, then clr+start+inc together
    repeat (3) begin drive(4'b0000, 4'b1000, 4'b0000, 1'b0, 2'd0, 8'd0, 2'd0); tick("ch3_up"); end
    drive(4'b1000, 4'b1000, 4'b1000, 1'b0, 2'd0, 8'd0, 2'd0);
    tick("clr_prio");
    checks++;
    if (count_o[3*W +: W] !== 8'd0 || busy_o[3] !== 1'b0 || event_o[3] !== 1'b0) begin
      errors++;
      $display("FAIL clr_priority: got count3=%h busy3=%b ev3=%b, want 00 0 0",
               count_o[3*W +: W], busy_o[3], event_o[3]);
    end

    // cfg write to running ch0 (limit 3) must be dropped
    drive(4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd0, 8'd1, 2'd2);
    tick("cfg_run_ignored");
    repeat (2) begin drive(4'b0000, 4'b0001, 4'b0000, 1'b0, 2'd0, 8'd0, 2'd0); tick("ch0_inc"); end
    checks++;
    if (count_o[W-1:0] !== 8'd2 || event_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL cfg_while_run: got count0=%h ev0=%b, want 02 0", count_o[W-1:0], event_o[0]);
    end

    // default limit 0xFF wrap: 256 incs -> exactly one event
    @(posedge clk); #1;
    do_reset();
    drive(4'b1000, 4'b0000, 4'b0000, 1'b0, 2'd0, 8'd0, 2'd0);
    tick("default_start");
    ev_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      drive(4'b0000, 4'b1000, 4'b0000, 1'b0, 2'd0, 8'd0, 2'd0);
      tick("default_wrap");
      if (event_o[3]) ev_cnt++;
    end
    checks++;
    if (ev_cnt != 1 || count_o[3*W +: W] !== 8'd0) begin
      errors++;
      $display("FAIL default_wrap: got events=%0d count3=%h, want 1 00", ev_cnt, count_o[3*W +: W]);
    end

    // reset mid-run at count 100
    for (int i = 0; i < 100; i++) begin
      drive(4'b0000, 4'b1000, 4'b0000, 1'b0, 2'd0, 8'd0, 2'd0);
      tick("to_100");
    end
    do_reset();
    checks++;
    if (count_o !== '0 || event_o !== '0 || done_o !== '0 || busy_o !== '0 || any_event_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got count=%h ev=%b done=%b busy=%b, want all zero",
               count_o, event_o, done_o, busy_o);
    end
    drive(4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd0, 8'd0, 2'd0);
    tick("start_after_reset");

    // random traffic against the model, with a reset in the middle
    for (int i = 0; i < 1500; i++) begin
      drive(4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15)),
            4'($urandom_range(0, 15) | $urandom_range(0, 15)),
            4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0),
            2'($urandom_range(0, 3)),
            8'($urandom_range(0, 6)),
            2'($urandom_range(0, 3)));
      tick("random");
      if (i == 700) do_reset();
    end

    idle();
    tick("final_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
